// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, disparity width and a byte popcount.
package tmds_pkg;

  // Signed running-disparity width; |cnt| never exceeds 8, so 5 bits suffice.
  localparam int TMDS_DISP_WIDTH = 5;

  // Control-period tokens indexed by {C1,C0}; bit 0 is transmitted first.
  localparam logic [9:0] TMDS_CTRL_TOKEN [4] = '{
    10'b1101010100,  // 00
    10'b0010101011,  // 01
    10'b0101010100,  // 10
    10'b1010101011   // 11
  };

  // Number of set bits in a byte (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] value);
    logic [3:0] total;
    total = '0;
    for (int i = 0; i < 8; i++) begin
      total = total + {3'b000, value[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/tmds_dc_balancer.sv
// TMDS DC-balance stage: picks the final 10-bit symbol from the transition-
// minimised word and tracks running disparity. Reusable by the data-island path.
module tmds_dc_balancer
  import tmds_pkg::*;
#(
  parameter int         DISP_WIDTH    = TMDS_DISP_WIDTH,  // must be >= 5
  parameter logic [1:0] RESET_CONTROL = 2'b00
) (
  input  logic       clock,
  input  logic       asyncReset,
  input  logic       enable,
  input  logic       dataEnable,
  input  logic [1:0] control,
  input  logic [8:0] qm,
  input  logic [3:0] onesQm,
  output logic [9:0] tmdsOut
);

  localparam logic signed [DISP_WIDTH-1:0] ZERO = '0;
  localparam logic signed [DISP_WIDTH-1:0] TWO  = DISP_WIDTH'(2);

  logic signed [DISP_WIDTH-1:0] cnt;
  logic signed [DISP_WIDTH-1:0] cntNext;
  logic signed [DISP_WIDTH-1:0] byteBalance;
  logic [9:0] symbolNext;
  logic cntPositive;
  logic cntNegative;
  logic moreOnes;
  logic moreZeros;

  // Symbol selection and next disparity; byteBalance = N1q - N0q = 2*N1q - 8.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    symbolNext  = '0;
    cntNext     = cnt;
    byteBalance = DISP_WIDTH'({onesQm, 1'b0}) - DISP_WIDTH'(8);
    cntPositive = !cnt[DISP_WIDTH-1] && (cnt != ZERO);
    cntNegative = cnt[DISP_WIDTH-1];
    moreOnes    = onesQm > 4'd4;
    moreZeros   = onesQm < 4'd4;

    if (!dataEnable) begin
      symbolNext = TMDS_CTRL_TOKEN[control];
      cntNext    = ZERO;
    end else if ((cnt == ZERO) || (onesQm == 4'd4)) begin
      symbolNext = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cntNext    = qm[8] ? (cnt + byteBalance) : (cnt - byteBalance);
    end else if ((cntPositive && moreOnes) || (cntNegative && moreZeros)) begin
      symbolNext = {1'b1, qm[8], ~qm[7:0]};
      cntNext    = cnt - byteBalance + (qm[8] ? TWO : ZERO);
    end else begin
      symbolNext = {1'b0, qm[8], qm[7:0]};
      cntNext    = cnt + byteBalance - (qm[8] ? ZERO : TWO);
    end
  end

  // Output symbol and disparity registers; both hold while enable is low.
  always_ff @(posedge clock or posedge asyncReset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (asyncReset) begin
      tmdsOut <= TMDS_CTRL_TOKEN[RESET_CONTROL];
      cnt     <= ZERO;
    end else if (enable) begin
      tmdsOut <= symbolNext;
      cnt     <= cntNext;
    end
  end

endmodule

// File: rtl/tmds_channel_encoder.sv
// DVI TMDS 8b/10b encoder for one channel: register, transition-minimise,
// DC-balance. One symbol per enabled clock, three enabled edges of latency.
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int         DISP_WIDTH    = TMDS_DISP_WIDTH,
  parameter logic [1:0] RESET_CONTROL = 2'b00
) (
  input  logic       clock,
  input  logic       asyncReset,
  input  logic       enable,
  input  logic       dataEnable,
  input  logic [1:0] control,
  input  logic [7:0] pixelData,
  output logic [9:0] tmdsOut
);

  // Stage 1 registers
  logic [7:0] s1Data;
  logic       s1De;
  logic [1:0] s1Control;
  logic [3:0] s1Ones;

  // Stage 2 registers
  logic [8:0] s2Qm;
  logic [3:0] s2Ones;
  logic       s2De;
  logic [1:0] s2Control;

  logic       useXnor;
  logic       chainBit;
  logic [8:0] qmComb;

  // Stage 1: capture inputs and the byte's ones count.
  always_ff @(posedge clock or posedge asyncReset) begin
    if (asyncReset) begin
      s1Data    <= '0;
      s1De      <= 1'b0;
      s1Control <= RESET_CONTROL;
      s1Ones    <= '0;
    end else if (enable) begin
      s1Data    <= pixelData;
      s1De      <= dataEnable;
      s1Control <= control;
      s1Ones    <= popcount8(pixelData);
    end
  end

  // Transition-minimising XOR/XNOR chain; q_m[8] flags which one was used.
  always_comb begin
    useXnor   = (s1Ones > 4'd4) || ((s1Ones == 4'd4) && !s1Data[0]);
    // NOTE: blocking here is intended; chainBit carries each bit into the next.
    chainBit  = s1Data[0];
    qmComb    = '0;
    qmComb[0] = chainBit;
    for (int i = 1; i < 8; i++) begin
      chainBit  = useXnor ? ~(chainBit ^ s1Data[i]) : (chainBit ^ s1Data[i]);
      qmComb[i] = chainBit;
    end
    qmComb[8] = ~useXnor;
  end

  // Stage 2: register q_m with its ones count for the balance decision.
  always_ff @(posedge clock or posedge asyncReset) begin
    if (asyncReset) begin
      s2Qm      <= '0;
      s2Ones    <= '0;
      s2De      <= 1'b0;
      s2Control <= RESET_CONTROL;
    end else if (enable) begin
      s2Qm      <= qmComb;
      s2Ones    <= popcount8(qmComb[7:0]);
      s2De      <= s1De;
      s2Control <= s1Control;
    end
  end

  // Stage 3: DC balance and running disparity.
  tmds_dc_balancer #(
    .DISP_WIDTH    (DISP_WIDTH),
    .RESET_CONTROL (RESET_CONTROL)
  ) balancer (
    .clock      (clock),
    .asyncReset (asyncReset),
    .enable     (enable),
    .dataEnable (s2De),
    .control    (s2Control),
    .qm         (s2Qm),
    .onesQm     (s2Ones),
    .tmdsOut    (tmdsOut)
  );

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: stimulus pushes expected symbols
// from a behavioural model, a monitor pops one per enabled edge and compares.
module tb_tmds_channel_encoder;

  logic       clock = 1'b0;
  logic       asyncReset;
  logic       enable;
  logic       dataEnable;
  logic [1:0] control;
  logic [7:0] pixelData;
  logic [9:0] tmdsOut;

  tmds_channel_encoder dut (
    .clock      (clock),
    .asyncReset (asyncReset),
    .enable     (enable),
    .dataEnable (dataEnable),
    .control    (control),
    .pixelData  (pixelData),
    .tmdsOut    (tmdsOut)
  );

  always #5 clock = ~clock;

  localparam logic [9:0] TOKENS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  typedef struct {
    logic [9:0] sym;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    int         cnt;
  } expect_t;

  expect_t    scoreboard [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         modelCnt = 0;
  logic [9:0] lastExpected = 10'h354;
  int         runSum = 0;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h (%0d), want 0x%0h (%0d) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Ones minus zeros of a 10-bit symbol.
  function automatic int balanceOf(input logic [9:0] s);
    return 2 * $countones(s) - 10;
  endfunction

  // Reference encoder: choose XOR/XNOR by byte weight, then invert the data
  // word whenever that pulls the running disparity back toward zero.
  function automatic logic [9:0] encodePixel(input logic [7:0] d, input int cntIn,
                                             output int cntOut);
    int         ones;
    int         qmOnes;
    logic       xnorMode;
    logic [8:0] qm;
    logic       invert;
    logic [9:0] sym;
    ones     = $countones(d);
    xnorMode = (ones > 4) || (ones == 4 && !d[0]);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = xnorMode ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8]  = !xnorMode;
    qmOnes = $countones(qm[7:0]);
    if (cntIn == 0 || qmOnes == 4) invert = !qm[8];
    else                           invert = ((cntIn > 0) == (qmOnes > 4));
    sym    = {invert, qm[8], invert ? ~qm[7:0] : qm[7:0]};
    cntOut = cntIn + balanceOf(sym);
    return sym;
  endfunction

  function automatic logic [7:0] decodePixel(input logic [9:0] s);
    logic [7:0] b;
    logic [7:0] d;
    b    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    end
    return d;
  endfunction

  function automatic int tokenIndex(input logic [9:0] s);
    for (int i = 0; i < 4; i++) begin
      if (TOKENS[i] == s) return i;
    end
    return -1;
  endfunction

  // Reset leaves two blanking symbols (reset control) in the pipeline.
  task automatic primeAfterReset();
    expect_t e;
    scoreboard.delete();
    e.sym = TOKENS[0]; e.de = 1'b0; e.ctrl = 2'b00; e.data = 8'h00; e.cnt = 0;
    scoreboard.push_back(e);
    scoreboard.push_back(e);
    modelCnt = 0;
  endtask

  task automatic issue(input logic de, input logic [1:0] ctrl, input logic [7:0] data,
                       input bit directed, input logic [9:0] dSym, input int dCnt);
    expect_t e;
    int      nextCnt;
    @(negedge clock);
    enable     = 1'b1;
    dataEnable = de;
    control    = ctrl;
    pixelData  = data;
    if (de) begin
      e.sym = encodePixel(data, modelCnt, nextCnt);
    end else begin
      e.sym   = TOKENS[ctrl];
      nextCnt = 0;
    end
    modelCnt = nextCnt;
    e.de   = de;
    e.ctrl = ctrl;
    e.data = data;
    e.cnt  = nextCnt;
    if (directed) begin
      e.sym = dSym;
      e.cnt = dCnt;
    end
    scoreboard.push_back(e);
  endtask

  task automatic idle();
    @(negedge clock);
    enable     = 1'b0;
    dataEnable = 1'($urandom_range(0, 1));
    control    = 2'($urandom_range(0, 3));
    pixelData  = 8'($urandom_range(0, 255));
  endtask

  task automatic midFrameReset();
    @(negedge clock);
    #2 asyncReset = 1'b1;
    #1 check("async_reset_immediate", int'(tmdsOut), 'h354);
    @(negedge clock);
    asyncReset = 1'b0;
    enable     = 1'b0;
    primeAfterReset();
  endtask

  // Monitor: one scoreboard entry per enabled edge; hold check otherwise.
  logic    monEn;
  logic    monRst;
  expect_t monItem;
  always @(posedge clock) begin
    monEn  = enable;
    monRst = asyncReset;
    #1;
    if (monRst || asyncReset) begin
      check("reset_token", int'(tmdsOut), 'h354);
      runSum       = 0;
      lastExpected = 10'h354;
    end else if (monEn) begin
      if (scoreboard.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_underflow: got symbol 0x%0h with no expectation at %0t",
                 tmdsOut, $time);
      end else begin
        monItem = scoreboard.pop_front();
        check("symbol", int'(tmdsOut), int'(monItem.sym));
        lastExpected = monItem.sym;
        if (monItem.de) begin
          check("decoded_pixel", int'(decodePixel(tmdsOut)), int'(monItem.data));
          runSum += balanceOf(tmdsOut);
          check("running_disparity", runSum, monItem.cnt);
          check("disparity_bound", int'(runSum <= 8 && runSum >= -8), 1);
        end else begin
          check("decoded_control", tokenIndex(tmdsOut), int'(monItem.ctrl));
          runSum = 0;
        end
      end
    end else begin
      check("hold_while_disabled", int'(tmdsOut), int'(lastExpected));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    asyncReset = 1'b1;
    enable     = 1'b0;
    dataEnable = 1'b0;
    control    = 2'b00;
    pixelData  = 8'h00;
    #1 check("reset_immediate", int'(tmdsOut), 'h354);

    // Inputs wiggle while reset is held; output must stay on the reset token.
    repeat (4) begin
      @(negedge clock);
      enable     = 1'($urandom_range(0, 1));
      dataEnable = 1'($urandom_range(0, 1));
      control    = 2'($urandom_range(0, 3));
      pixelData  = 8'($urandom_range(0, 255));
    end
    @(negedge clock);
    asyncReset = 1'b0;
    enable     = 1'b0;
    primeAfterReset();

    // Control tokens.
    issue(1'b0, 2'b00, 8'h5A, 1'b1, 10'h354, 0);
    issue(1'b0, 2'b01, 8'hA5, 1'b1, 10'h0AB, 0);
    issue(1'b0, 2'b10, 8'h3C, 1'b1, 10'h154, 0);
    issue(1'b0, 2'b11, 8'hC3, 1'b1, 10'h2AB, 0);

    // 0x00 run from blanking.
    issue(1'b1, 2'b00, 8'h00, 1'b1, 10'h100, -8);
    issue(1'b1, 2'b00, 8'h00, 1'b1, 10'h3FF,  2);
    issue(1'b1, 2'b00, 8'h00, 1'b1, 10'h100, -6);

    // 0xFF as the first pixel after blanking.
    issue(1'b0, 2'b00, 8'h00, 1'b1, 10'h354, 0);
    issue(1'b1, 2'b00, 8'hFF, 1'b1, 10'h200, -8);

    // Enable pattern 1,0,0,1,1 with changing pixel data.
    issue(1'b1, 2'b00, 8'h12, 1'b0, 10'h000, 0);
    idle();
    idle();
    issue(1'b1, 2'b00, 8'h34, 1'b0, 10'h000, 0);
    issue(1'b1, 2'b00, 8'h56, 1'b0, 10'h000, 0);

    // Random traffic with random DE, control and enable gaps.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 6) == 0) idle();
      issue(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 1'b0, 10'h000, 0);
      if (i == 5000) midFrameReset();
    end

    @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("pipeline_residue", scoreboard.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
